// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder; the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: computes a+b+cin LSB first over WIDTH cycles with one full adder.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry, cout_r;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_c;
  logic             accept, last_bit;

  // Operands are only taken when no addition is in flight (IDLE or DONE).
  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (cnt == LAST_BIT);

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = start ? ADD : IDLE;
      ADD:     state_nxt = last_bit ? DONE : ADD;
      DONE:    state_nxt = start ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ADD);
    done = (state == DONE);
  end

  // cout has its own flop so a new accept (which reloads carry) leaves the old result intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == ADD) begin
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_c;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) cout_r <= fa_c;
    end
  end

  assign sum  = sum_sh;
  assign cout = cout_r;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A; sampled only on the accept edge.
REQ-006 b  input  WIDTH  operand B; sampled only on the accept edge.
REQ-007 cin  input  1  carry-in; sampled only on the accept edge.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  single-cycle pulse marking result valid.
REQ-010 sum  output  WIDTH  result; held stable from done until the next accept.
REQ-011 cout  output  1  carry-out of bit WIDTH-1; held like sum.

Function
REQ-012 The block SHALL add a+b+cin bit-serially, LSB first, using one 1-bit full-adder datapath once per cycle.
REQ-013 FSM states SHALL be IDLE, ADD and DONE.
REQ-014 IDLE: start=1 at an edge -> load a, b into shift registers, load carry register with cin, clear bit counter, go to ADD; start=0 -> stay in IDLE.
REQ-015 ADD: each edge SHALL add LSB(a_sh) + LSB(b_sh) + carry, shift the sum bit into the result register from the MSB side, shift both operands right, update carry and increment the counter.
REQ-016 ADD SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 SHALL move to DONE.
REQ-017 DONE SHALL last one cycle; start=1 in DONE is accepted exactly as in IDLE (back-to-back), else go to IDLE.
REQ-018 Latency: if start is accepted at edge 0, done SHALL be high in the cycle after edge WIDTH, with sum/cout valid in that same cycle.
REQ-019 busy SHALL equal (state==ADD); done SHALL equal (state==DONE); both are registered-state decodes with no combinational path from start.
REQ-020 start while busy=1 SHALL be ignored, with no effect on operands, result or timing.
REQ-021 a, b and cin changing after the accept edge SHALL NOT affect the result in flight.
REQ-022 sum/cout SHALL keep the last result through IDLE; a new accept SHALL NOT clear them until bits shift in.
REQ-023 Arithmetic is modulo 2^WIDTH in sum, with overflow reported only via cout; there is no signed interpretation.
REQ-024 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL not wrap inside one operation.

Reset
REQ-025 rst_n low SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry and shift registers immediately, without waiting for clk.
REQ-026 Reset during ADD SHALL abandon the operation with no done pulse; the first accept after release SHALL behave as from power-up.
REQ-027 Release of rst_n SHALL take effect on the first rising clk at which rst_n is high.

Structure
REQ-028 A package serial_adder_pkg SHALL hold the state enum typedef (IDLE, ADD, DONE) and the default WIDTH constant.
REQ-029 Sub-module full_adder (a, b, cin -> s, cout), purely combinational, SHALL be the only arithmetic in the block, with one instance.
REQ-030 All other logic (FSM, counter, shift registers, carry flop) SHALL reside in serial_adder_ctrl.

Verification (WIDTH=8)
REQ-031 Basic: a=0x3C, b=0x5A, cin=0, start pulse at edge 0 -> busy high for 8 cycles, done in the cycle after edge 8, sum=0x96, cout=0.
REQ-032 Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-033 Busy collision: accept 0x10+0x20; at edge 3 drive start=1, a=0xAA, b=0x55 -> result 0x30, cout=0, one done only.
REQ-034 Back-to-back: start held high continuously with 0x01+0x01, then 0x80+0x80 presented in the DONE cycle -> done pulses 9 cycles apart, results 0x02/c0 then 0x00/c1.
REQ-035 Reset mid-op: assert rst_n=0 between edges 4 and 5 of 0x7F+0x01 -> outputs 0 asynchronously, no done; a subsequent 0x7F+0x01 gives 0x80, cout=0.
REQ-036 Sweep: random a, b, cin (>=1000 ops, random start gaps) checked against a reference model for sum, cout and the done timing.
